// File: rtl/morse_pkg.sv
// Shared definitions for the morse transmit queue: symbol codes, interval
// lengths in morse units, player states and the pattern builder.
package morse_pkg;

    // Two-bit symbol codes; a pattern holds five of them, first symbol in [9:8].
    localparam logic [1:0] SYM_END  = 2'b00;
    localparam logic [1:0] SYM_DOT  = 2'b01;
    localparam logic [1:0] SYM_DASH = 2'b10;

    // Interval lengths in morse time units.
    localparam logic [2:0] DOT_U  = 3'd1;
    localparam logic [2:0] DASH_U = 3'd3;
    localparam logic [2:0] GAP_U  = 3'd1;
    localparam logic [2:0] CGAP_U = 3'd3;
    localparam logic [2:0] WGAP_U = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MARK  = 3'd2,
        ST_SPACE = 3'd3,
        ST_CGAP  = 3'd4,
        ST_WGAP  = 3'd5
    } state_t;

    // Both 00 and 11 terminate a pattern.
    function automatic logic sym_is_end(input logic [1:0] sym);
        return (sym == SYM_END) || (sym == 2'b11);
    endfunction

    // Build a pattern from a symbol count and a dash mask (mask[4] = first
    // symbol, 1 = dash, 0 = dot); unused trailing slots stay SYM_END.
    function automatic logic [9:0] enc(input logic [2:0] len, input logic [4:0] dash);
        logic [9:0] p;
        p = '0;
        for (int i = 0; i < 5; i++) begin
            if (i < int'(len)) begin
                p[9 - 2 * i -: 2] = dash[4 - i] ? SYM_DASH : SYM_DOT;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational ASCII to morse pattern lookup. Lower-case letters fold onto
// upper case; 0x20 reports a word space; anything else is invalid.
module morse_rom
    import morse_pkg::*;
(
    input  logic [7:0] ch,
    output logic       valid,
    output logic       is_space,
    output logic [9:0] pattern
);

    logic [7:0] up;

    // Fold case, then map the character to its ITU pattern.
    always_comb begin
        up       = ((ch >= 8'h61) && (ch <= 8'h7a)) ? (ch - 8'h20) : ch;
        valid    = 1'b1;
        is_space = 1'b0;
        pattern  = '0;
        case (up)
            8'h20: is_space = 1'b1;
            "A": pattern = enc(3'd2, 5'b01000);
            "B": pattern = enc(3'd4, 5'b10000);
            "C": pattern = enc(3'd4, 5'b10100);
            "D": pattern = enc(3'd3, 5'b10000);
            "E": pattern = enc(3'd1, 5'b00000);
            "F": pattern = enc(3'd4, 5'b00100);
            "G": pattern = enc(3'd3, 5'b11000);
            "H": pattern = enc(3'd4, 5'b00000);
            "I": pattern = enc(3'd2, 5'b00000);
            "J": pattern = enc(3'd4, 5'b01110);
            "K": pattern = enc(3'd3, 5'b10100);
            "L": pattern = enc(3'd4, 5'b01000);
            "M": pattern = enc(3'd2, 5'b11000);
            "N": pattern = enc(3'd2, 5'b10000);
            "O": pattern = enc(3'd3, 5'b11100);
            "P": pattern = enc(3'd4, 5'b01100);
            "Q": pattern = enc(3'd4, 5'b11010);
            "R": pattern = enc(3'd3, 5'b01000);
            "S": pattern = enc(3'd3, 5'b00000);
            "T": pattern = enc(3'd1, 5'b10000);
            "U": pattern = enc(3'd3, 5'b00100);
            "V": pattern = enc(3'd4, 5'b00010);
            "W": pattern = enc(3'd3, 5'b01100);
            "X": pattern = enc(3'd4, 5'b10010);
            "Y": pattern = enc(3'd4, 5'b10110);
            "Z": pattern = enc(3'd4, 5'b11000);
            "0": pattern = enc(3'd5, 5'b11111);
            "1": pattern = enc(3'd5, 5'b01111);
            "2": pattern = enc(3'd5, 5'b00111);
            "3": pattern = enc(3'd5, 5'b00011);
            "4": pattern = enc(3'd5, 5'b00001);
            "5": pattern = enc(3'd5, 5'b00000);
            "6": pattern = enc(3'd5, 5'b10000);
            "7": pattern = enc(3'd5, 5'b11000);
            "8": pattern = enc(3'd5, 5'b11100);
            "9": pattern = enc(3'd5, 5'b11110);
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_tx_queue.sv
// Character FIFO feeding a morse player. Each popped character is encoded and
// played as timed marks (tone_on high) and spaces, with a start pulse on
// short (dot) or long (dash) at the first cycle of every mark.
module morse_tx_queue
    import morse_pkg::*;
#(
    parameter int UNIT_TICKS = 6_000_000,
    parameter int CW         = 24,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       ovf,
    output logic       char_err,
    output logic       busy,
    output logic       tone_on,
    output logic       short,
    output logic       long,
    output logic [9:0] morse_code
);

    localparam int             DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [CW-1:0]  TICK_LAST = CW'(UNIT_TICKS - 1);

    // Write handshake: wr_en is a one-cycle strobe; the character is taken on
    // that edge when the FIFO is not full, or when it is full but the player
    // pops at the same edge. Otherwise it is dropped and ovf pulses.

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr, rd_ptr;
    logic                  empty, push, pop;

    logic [7:0]            cur_char;
    logic                  rom_valid, rom_space;
    logic [9:0]            rom_pattern;

    state_t                state, state_next;
    logic [CW-1:0]         tick_cnt;
    logic [2:0]            unit_cnt;
    logic [9:0]            shreg;
    logic [9:0]            shreg_adv;
    logic [2:0]            target;
    logic                  unit_end, span_done;
    logic [1:0]            next_sym;
    logic                  enter_mark;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign pop   = (state == ST_IDLE) && !empty;
    assign push  = wr_en && (!full || pop);
    assign busy  = !empty || (state != ST_IDLE);

    morse_rom u_rom (
        .ch       (cur_char),
        .valid    (rom_valid),
        .is_space (rom_space),
        .pattern  (rom_pattern)
    );

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    // FIFO pointers and the character handed to the player on pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cur_char <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                cur_char <= mem[rd_ptr[DEPTH_LOG2-1:0]];
            end
        end
    end

    // Next-state logic: interval length per state and symbol sequencing.
    always_comb begin
        state_next = state;
        shreg_adv  = {shreg[7:0], 2'b00};
        unit_end   = (tick_cnt == TICK_LAST);
        case (state)
            ST_MARK:  target = (shreg[9:8] == SYM_DASH) ? DASH_U : DOT_U;
            ST_SPACE: target = GAP_U;
            ST_CGAP:  target = CGAP_U;
            ST_WGAP:  target = WGAP_U;
            default:  target = 3'd1;
        endcase
        span_done = unit_end && (unit_cnt == (target - 3'd1));
        case (state)
            ST_IDLE:  if (!empty) state_next = ST_LOAD;
            ST_LOAD: begin
                if (!rom_valid)     state_next = ST_IDLE;
                else if (rom_space) state_next = ST_WGAP;
                else                state_next = ST_MARK;
            end
            ST_MARK: begin
                if (span_done) state_next = sym_is_end(shreg_adv[9:8]) ? ST_CGAP : ST_SPACE;
            end
            ST_SPACE: if (span_done) state_next = ST_MARK;
            ST_CGAP:  if (span_done) state_next = ST_IDLE;
            ST_WGAP:  if (span_done) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        next_sym   = (state == ST_LOAD) ? rom_pattern[9:8] : shreg[9:8];
        enter_mark = (state_next == ST_MARK) && (state != ST_MARK);
    end

    // State register plus tick/unit counters, reloaded on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            unit_cnt <= '0;
        end else begin
            state <= state_next;
            if ((state_next != state) || (state == ST_IDLE) || (state == ST_LOAD)) begin
                tick_cnt <= '0;
                unit_cnt <= '0;
            end else if (unit_end) begin
                tick_cnt <= '0;
                unit_cnt <= unit_cnt + 3'd1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    // Symbol shift register and the displayed pattern of the current character.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg      <= '0;
            morse_code <= '0;
        end else begin
            if (state == ST_LOAD) begin
                shreg <= rom_pattern;
                if (rom_valid) morse_code <= rom_pattern;
            end else if (state_next == ST_IDLE) begin
                shreg      <= '0;
                morse_code <= '0;
            end else if ((state == ST_MARK) && span_done) begin
                shreg <= shreg_adv;
            end
        end
    end

    // Registered outputs: tone level, mark start pulses and error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tone_on  <= 1'b0;
            short    <= 1'b0;
            long     <= 1'b0;
            char_err <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            tone_on  <= (state_next == ST_MARK);
            short    <= enter_mark && (next_sym == SYM_DOT);
            long     <= enter_mark && (next_sym == SYM_DASH);
            char_err <= (state == ST_LOAD) && !rom_valid;
            ovf      <= wr_en && full && !pop;
        end
    end

endmodule
